// File: rtl/pcihellocore_led_seq_pkg.sv
// ---------------------------------------------------------------------------
// pcihellocore_led_seq_pkg : shared encodings for the LED pattern sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pcihellocore_led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_ROT_L  = 2'd2,
    MODE_ROT_R  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_MODE_LSB   = 0;
  localparam int CTRL_MODE_MSB   = 1;
  localparam int CTRL_ENABLE_BIT = 2;

endpackage

`default_nettype wire

// File: rtl/pcihellocore_led_prescaler.sv
// ---------------------------------------------------------------------------
// pcihellocore_led_prescaler : reloadable down-counter producing step ticks
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pcihellocore_led_prescaler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload;

  // A period of zero behaves as one, i.e. a tick every RUN cycle.
  always_comb begin
    reload = (period == '0) ? '0 : period - WIDTH'(1);
    tick   = run && (count_q == '0);
    count_d = count_q;
    if (load || tick) begin
      count_d = reload;
    end else if (run) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcihellocore_led_sequencer.sv
// ---------------------------------------------------------------------------
// pcihellocore_led_sequencer : Avalon-MM LED pattern engine (static/blink/rotate)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pcihellocore_led_sequencer
  import pcihellocore_led_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] out_port
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             enable_q, enable_d;
  logic             phase_q, phase_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] step_count_q, step_count_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic wr, wr_data, wr_ctrl, wr_period, wr_status;
  logic ctrl_en_wr, ctrl_dis_wr;
  logic tick, step_en;

  always_comb begin
    wr          = chipselect && !write_n;
    wr_data     = wr && (address == ADDR_DATA);
    wr_ctrl     = wr && (address == ADDR_CTRL);
    wr_period   = wr && (address == ADDR_PERIOD);
    wr_status   = wr && (address == ADDR_STATUS);
    ctrl_en_wr  = wr_ctrl &&  writedata[CTRL_ENABLE_BIT];
    ctrl_dis_wr = wr_ctrl && !writedata[CTRL_ENABLE_BIT];
    // Host DATA/CTRL writes take priority over a coincident tick.
    step_en     = tick && !(wr_data || wr_ctrl);
  end

  pcihellocore_led_prescaler #(.WIDTH(WIDTH)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state_q == ST_LOAD),
    .run     (state_q == ST_RUN),
    .period  (period_q),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ctrl_dis_wr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (ctrl_en_wr) state_d = ST_LOAD;
        ST_LOAD: state_d = ST_RUN;
        ST_RUN:  if (wr_data || ctrl_en_wr) state_d = ST_LOAD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_d   = out_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: out_d = wr_data ? writedata : pattern_q;
      ST_LOAD: begin
        out_d   = pattern_q;
        phase_d = 1'b0;
      end
      ST_RUN: begin
        if (step_en) begin
          case (mode_q)
            MODE_BLINK: begin
              phase_d = !phase_q;
              out_d   = phase_q ? pattern_q : '0;
            end
            MODE_ROT_L: out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            MODE_ROT_R: out_d = {out_q[0], out_q[WIDTH-1:1]};
            default:    out_d = out_q;
          endcase
        end
      end
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    pattern_d    = wr_data   ? writedata : pattern_q;
    period_d     = wr_period ? writedata : period_q;
    mode_d       = wr_ctrl   ? mode_e'(writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]) : mode_q;
    enable_d     = wr_ctrl   ? writedata[CTRL_ENABLE_BIT] : enable_q;
    step_count_d = step_count_q;
    if (wr_status) begin
      step_count_d = '0;
    end else if (step_en) begin
      step_count_d = step_count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q    <= '0;
      period_q     <= '0;
      mode_q       <= MODE_STATIC;
      enable_q     <= 1'b0;
      step_count_q <= '0;
      out_q        <= '0;
      phase_q      <= 1'b0;
    end else begin
      pattern_q    <= pattern_d;
      period_q     <= period_d;
      mode_q       <= mode_d;
      enable_q     <= enable_d;
      step_count_q <= step_count_d;
      out_q        <= out_d;
      phase_q      <= phase_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = out_q;
      ADDR_CTRL: begin
        readdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
        readdata[CTRL_ENABLE_BIT]             = enable_q;
      end
      ADDR_PERIOD: readdata = period_q;
      default:     readdata = step_count_q;
    endcase
  end

  assign out_port = out_q;

endmodule

`default_nettype wire
